multicycle_ctrl: RTL and testbench

- Multi-cycle sequencer for the rv32i core. Steps the shared datapath through FETCH/DECODE/EXEC/MEM/WB.
- Takes decoded intent from the combinational control decoder: reg_write, mem_write, branch.
- Runs the instruction- and data-memory request/ready handshakes, gates all architectural state writes (IR, PC, regfile), and traps on illegal opcodes or memory timeouts.

---
 rtl/multicycle_ctrl_pkg.sv | 38 +++
 rtl/multicycle_ctrl_if.sv | 18 +
 rtl/multicycle_ctrl_mem_wait_timer.sv | 32 +++
 rtl/multicycle_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the rv32i multi-cycle sequencer: FSM states, trap causes
// and the base-ISA opcodes the decoder accepts.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        MC_FETCH  = 3'd0,
        MC_DECODE = 3'd1,
        MC_EXEC   = 3'd2,
        MC_MEM    = 3'd3,
        MC_WB     = 3'd4,
        MC_TRAP   = 3'd7
    } mc_state_e;

    typedef enum logic [1:0] {
        TRAP_NONE    = 2'b00,
        TRAP_ILLEGAL = 2'b01,
        TRAP_IMEM_TO = 2'b10,
        TRAP_DMEM_TO = 2'b11
    } trap_cause_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    function automatic logic opcode_legal(input logic [6:0] op);
        case (op)
            OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE,
            OPC_BRANCH, OPC_JAL, OPC_LUI, OPC_AUIPC: opcode_legal = 1'b1;
            default:                                 opcode_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Instruction/data memory request-ready handshake between the sequencer and memories.
interface multicycle_ctrl_if;
    logic imem_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ready;

    modport master (
        output imem_req, dmem_req, dmem_we,
        input  imem_ready, dmem_ready
    );

    modport slave (
        input  imem_req, dmem_req, dmem_we,
        output imem_ready, dmem_ready
    );
endinterface

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Memory wait counter: clear/enable, expired when the next count would reach MEM_TIMEOUT-1.
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_WIDTH   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(MEM_TIMEOUT - 1);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;

    // expired looks at the incremented value so the trap edge coincides with the
    // counter reaching its limit; it must not depend on clr (clr derives from it).
    always_comb begin
        cnt_inc = cnt_q + CNT_WIDTH'(1);
        cnt_d   = cnt_q;
        if (clr)     cnt_d = '0;
        else if (en) cnt_d = cnt_inc;
        expired = en && (cnt_inc == LIMIT);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// rv32i multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB with memory-timeout and illegal-opcode traps.
// Optional perf counters (cycle_cnt, instret_cnt) under `define MCYC_PERF_CNT_EN.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_WIDTH   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [6:0]         opcode,
    input  logic               ctrl_reg_write,
    input  logic               ctrl_mem_write,
    input  logic               ctrl_branch,
    multicycle_ctrl_if.master  mem,
    output logic               ir_write,
    output logic               pc_write,
    output logic               pc_sel,
    output logic               reg_write_en,
    output logic               retire,
    output logic [2:0]         state_o,
    output logic               trap,
    output logic [1:0]         trap_cause
`ifdef MCYC_PERF_CNT_EN
    ,
    output logic [31:0]        cycle_cnt,
    output logic [31:0]        instret_cnt
`endif
);

    mc_state_e   state_q, state_d;
    trap_cause_e trap_cause_q, trap_cause_d;
    logic        imem_req, dmem_req, dmem_we;
    logic        tmr_en, tmr_clr, tmr_expired;

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_WIDTH   (CNT_WIDTH)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d      = state_q;
        trap_cause_d = trap_cause_q;
        imem_req     = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_sel       = 1'b0;
        reg_write_en = 1'b0;
        retire       = 1'b0;
        tmr_en       = 1'b0;

        case (state_q)
            MC_FETCH: begin
                imem_req = 1'b1;
                if (mem.imem_ready) begin
                    ir_write = 1'b1;
                    state_d  = MC_DECODE;
                end else begin
                    tmr_en = 1'b1;
                    if (tmr_expired) begin
                        state_d      = MC_TRAP;
                        trap_cause_d = TRAP_IMEM_TO;
                    end
                end
            end
            MC_DECODE: begin
                if (opcode_legal(opcode)) begin
                    state_d = MC_EXEC;
                end else begin
                    state_d      = MC_TRAP;
                    trap_cause_d = TRAP_ILLEGAL;
                end
            end
            MC_EXEC: begin
                if (opcode == OPC_LOAD || opcode == OPC_STORE) begin
                    state_d = MC_MEM;
                end else if (opcode == OPC_BRANCH) begin
                    pc_write = 1'b1;
                    pc_sel   = ctrl_branch;
                    retire   = 1'b1;
                    state_d  = MC_FETCH;
                end else begin
                    state_d = MC_WB;
                end
            end
            MC_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = ctrl_mem_write;
                if (mem.dmem_ready) begin
                    if (opcode == OPC_STORE) begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                        state_d  = MC_FETCH;
                    end else begin
                        state_d = MC_WB;
                    end
                end else begin
                    tmr_en = 1'b1;
                    if (tmr_expired) begin
                        state_d      = MC_TRAP;
                        trap_cause_d = TRAP_DMEM_TO;
                    end
                end
            end
            MC_WB: begin
                reg_write_en = ctrl_reg_write;
                pc_write     = 1'b1;
                pc_sel       = ctrl_branch;
                retire       = 1'b1;
                state_d      = MC_FETCH;
            end
            MC_TRAP: ;
            default: state_d = MC_FETCH;
        endcase

        // Reset overrides any in-flight handshake, including same-cycle strobes.
        if (rst) begin
            state_d      = MC_FETCH;
            trap_cause_d = TRAP_NONE;
            imem_req     = 1'b0;
            dmem_req     = 1'b0;
            dmem_we      = 1'b0;
            ir_write     = 1'b0;
            pc_write     = 1'b0;
            pc_sel       = 1'b0;
            reg_write_en = 1'b0;
            retire       = 1'b0;
            tmr_en       = 1'b0;
        end

        tmr_clr = (state_d != state_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= MC_FETCH;
            trap_cause_q <= TRAP_NONE;
        end else begin
            state_q      <= state_d;
            trap_cause_q <= trap_cause_d;
        end
    end

    assign mem.imem_req = imem_req;
    assign mem.dmem_req = dmem_req;
    assign mem.dmem_we  = dmem_we;
    assign state_o      = state_q;
    assign trap         = (state_q == MC_TRAP);
    assign trap_cause   = trap_cause_q;

`ifdef MCYC_PERF_CNT_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d, instret_cnt_q, instret_cnt_d;

    always_comb begin
        cycle_cnt_d   = cycle_cnt_q + 32'd1;
        instret_cnt_d = instret_cnt_q + {31'd0, retire};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            cycle_cnt_q   <= cycle_cnt_d;
            instret_cnt_q <= instret_cnt_d;
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: directed instruction programs with hand-computed retire/trap timing.
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    typedef struct {
        logic [6:0] op;
        logic       rw, mw, br;
        int         iwait, dwait;
        bit         stray;
    } instr_t;

    typedef struct {
        bit         is_trap;
        int         cyc;
        logic       pc_sel;
        int         rwe, imreq, we;
        logic [1:0] cause;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic       ctrl_reg_write, ctrl_mem_write, ctrl_branch;
    logic       ir_write, pc_write, pc_sel, reg_write_en, retire, trap;
    logic [2:0] state_o;
    logic [1:0] trap_cause;
`ifdef MCYC_PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    multicycle_ctrl_if mif ();

    multicycle_ctrl #(
        .MEM_TIMEOUT (16),
        .CNT_WIDTH   (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .opcode         (opcode),
        .ctrl_reg_write (ctrl_reg_write),
        .ctrl_mem_write (ctrl_mem_write),
        .ctrl_branch    (ctrl_branch),
        .mem            (mif),
        .ir_write       (ir_write),
        .pc_write       (pc_write),
        .pc_sel         (pc_sel),
        .reg_write_en   (reg_write_en),
        .retire         (retire),
        .state_o        (state_o),
        .trap           (trap),
        .trap_cause     (trap_cause)
`ifdef MCYC_PERF_CNT_EN
        ,
        .cycle_cnt      (cycle_cnt),
        .instret_cnt    (instret_cnt)
`endif
    );

    always #5 clk = ~clk;

    int     vectors = 0;
    int     miscompares = 0;
    exp_t   exp_q[$];
    instr_t prog[$];

    int         mcyc = 0;
    int         n_ir, n_pcw, n_rwe, n_imreq, n_we;
    bit         trap_prev = 1'b0;
    logic [1:0] last_cause = 2'b00;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic instr_t mk(input logic [6:0] op, input logic rw, input logic mw,
                                  input logic br, input int iwait, input int dwait,
                                  input bit stray);
        instr_t t;
        t.op = op; t.rw = rw; t.mw = mw; t.br = br;
        t.iwait = iwait; t.dwait = dwait; t.stray = stray;
        return t;
    endfunction

    task automatic push_ret(input int cyc, input logic ps, input int rwe, input int imreq, input int we);
        exp_t e;
        e.is_trap = 1'b0; e.cyc = cyc; e.pc_sel = ps; e.rwe = rwe;
        e.imreq = imreq; e.we = we; e.cause = 2'b00;
        exp_q.push_back(e);
    endtask

    task automatic push_trap(input int cyc, input logic [1:0] cause);
        exp_t e;
        e.is_trap = 1'b1; e.cyc = cyc; e.pc_sel = 1'b0; e.rwe = 0;
        e.imreq = 0; e.we = 0; e.cause = cause;
        exp_q.push_back(e);
    endtask

    // Monitor: samples mid-cycle, pops an expectation on every retire or trap entry.
    always begin
        @(negedge clk);
        #3;
        if (rst) begin
            mcyc = 0; n_ir = 0; n_pcw = 0; n_rwe = 0; n_imreq = 0; n_we = 0;
            trap_prev = 1'b0;
        end else begin
            exp_t e;
            mcyc++;
            n_ir    += int'(ir_write);
            n_pcw   += int'(pc_write);
            n_rwe   += int'(reg_write_en);
            n_imreq += int'(mif.imem_req);
            n_we    += int'(mif.dmem_req & mif.dmem_we);
            if (retire) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_retire", 32'(mcyc), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_kind", 32'd1, e.is_trap ? 32'd2 : 32'd1);
                    chk("retire_cycle", 32'(mcyc), 32'(e.cyc));
                    chk("pc_sel", {31'd0, pc_sel}, {31'd0, e.pc_sel});
                    chk("pc_write_count", 32'(n_pcw), 32'd1);
                    chk("reg_write_count", 32'(n_rwe), 32'(e.rwe));
                    chk("ir_write_count", 32'(n_ir), 32'd1);
                    chk("imem_req_cycles", 32'(n_imreq), 32'(e.imreq));
                    chk("dmem_we_cycles", 32'(n_we), 32'(e.we));
                end
                n_ir = 0; n_pcw = 0; n_rwe = 0; n_imreq = 0; n_we = 0;
            end
            if (trap && !trap_prev) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_trap", 32'(mcyc), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_kind", 32'd2, e.is_trap ? 32'd2 : 32'd1);
                    chk("trap_cycle", 32'(mcyc), 32'(e.cyc));
                    chk("trap_cause", {30'd0, trap_cause}, {30'd0, e.cause});
                    chk("trap_pc_write", 32'(n_pcw), 32'd0);
                    chk("trap_reg_write", 32'(n_rwe), 32'd0);
                    last_cause = e.cause;
                end
                n_ir = 0; n_pcw = 0; n_rwe = 0; n_imreq = 0; n_we = 0;
            end else if (trap && trap_prev) begin
                chk("trap_hold_outputs",
                    {25'd0, mif.imem_req, mif.dmem_req, mif.dmem_we, ir_write, pc_write, reg_write_en, retire},
                    32'd0);
                chk("trap_hold_state", {29'd0, state_o}, 32'd7);
                chk("trap_hold_cause", {30'd0, trap_cause}, {30'd0, last_cause});
            end
            trap_prev = trap;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        mif.imem_ready = 1'b0;
        mif.dmem_ready = 1'b0;
        @(negedge clk);
        #2;
        chk("rst_state", {29'd0, state_o}, 32'd0);
        chk("rst_trap", {29'd0, trap, trap_cause}, 32'd0);
        chk("rst_strobes",
            {25'd0, mif.imem_req, mif.dmem_req, mif.dmem_we, ir_write, pc_write, reg_write_en, retire},
            32'd0);
`ifdef MCYC_PERF_CNT_EN
        chk("rst_cycle_cnt", cycle_cnt, 32'd0);
        chk("rst_instret_cnt", instret_cnt, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Memory responder: acks a fetch after iwait request cycles and loads the next
    // instruction's decode, acks data after dwait request cycles.
    task automatic run_prog(input int abort_at);
        instr_t cur;
        int     idx = 0;
        int     iw = 0;
        int     dw = 0;
        int     extra = 0;
        bit     done = 1'b0;
        cur = mk(OPC_OP, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        for (int c = 1; c <= 400 && !done; c++) begin
            #1;
            mif.imem_ready = 1'b0;
            mif.dmem_ready = 1'b0;
            if (mif.imem_req) begin
                if (idx < prog.size() && iw == prog[idx].iwait) begin
                    mif.imem_ready = 1'b1;
                    cur            = prog[idx];
                    opcode         = cur.op;
                    ctrl_reg_write = cur.rw;
                    ctrl_mem_write = cur.mw;
                    ctrl_branch    = cur.br;
                    idx++;
                    iw = 0;
                    dw = 0;
                end else begin
                    iw++;
                end
            end
            if (mif.dmem_req) begin
                if (dw == cur.dwait) begin
                    mif.dmem_ready = 1'b1;
                    dw = 0;
                end else begin
                    dw++;
                end
            end else if (cur.stray) begin
                mif.dmem_ready = 1'b1;
            end
            @(negedge clk);
            if (abort_at != 0) begin
                if (c == abort_at) done = 1'b1;
            end else if (exp_q.size() == 0) begin
                extra++;
                if (extra > 3) done = 1'b1;
            end
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL run_timeout: %0d expectations still pending after 400 cycles, expected 0", exp_q.size());
        end else begin
            chk("pending_expectations", 32'(exp_q.size()), 32'd0);
        end
        exp_q.delete();
        prog.delete();
    endtask

    initial begin
        rst = 1'b1;
        opcode = '0;
        ctrl_reg_write = 1'b0;
        ctrl_mem_write = 1'b0;
        ctrl_branch = 1'b0;
        mif.imem_ready = 1'b0;
        mif.dmem_ready = 1'b0;
        do_reset();

        // Zero-wait ADD, LW, SW, taken BEQ.
        prog.push_back(mk(OPC_OP,     1, 0, 0, 0, 0, 0));
        prog.push_back(mk(OPC_LOAD,   1, 0, 0, 0, 0, 0));
        prog.push_back(mk(OPC_STORE,  0, 1, 0, 0, 0, 0));
        prog.push_back(mk(OPC_BRANCH, 0, 0, 1, 0, 0, 0));
        push_ret(4,  0, 1, 1, 0);
        push_ret(9,  0, 1, 1, 0);
        push_ret(13, 0, 0, 1, 1);
        push_ret(16, 1, 0, 1, 0);
        run_prog(0);
        do_reset();

        // Wait states, ready exactly at the timeout limit, stray dmem_ready.
        prog.push_back(mk(OPC_OP,     1, 0, 0, 3,  0,  0));
        prog.push_back(mk(OPC_JAL,    1, 0, 1, 0,  0,  0));
        prog.push_back(mk(OPC_BRANCH, 0, 0, 0, 0,  0,  0));
        prog.push_back(mk(OPC_LOAD,   1, 0, 0, 0,  2,  0));
        prog.push_back(mk(OPC_LUI,    1, 0, 0, 0,  0,  1));
        prog.push_back(mk(OPC_OP,     1, 0, 0, 14, 0,  0));
        prog.push_back(mk(OPC_LOAD,   1, 0, 0, 0,  14, 0));
        prog.push_back(mk(OPC_STORE,  0, 1, 0, 0,  1,  0));
        prog.push_back(mk(OPC_AUIPC,  1, 0, 0, 0,  0,  0));
        prog.push_back(mk(OPC_OP_IMM, 1, 0, 0, 0,  0,  0));
        push_ret(7,  0, 1, 4,  0);
        push_ret(11, 1, 1, 1,  0);
        push_ret(14, 0, 0, 1,  0);
        push_ret(21, 0, 1, 1,  0);
        push_ret(25, 0, 1, 1,  0);
        push_ret(43, 0, 1, 15, 0);
        push_ret(62, 0, 1, 1,  0);
        push_ret(67, 0, 0, 1,  2);
        push_ret(71, 0, 1, 1,  0);
        push_ret(75, 0, 1, 1,  0);
        run_prog(0);
        do_reset();

        // Data memory never ready: 15 MEM cycles then trap.
        prog.push_back(mk(OPC_LOAD, 1, 0, 0, 0, 255, 0));
        push_trap(19, 2'b11);
        run_prog(0);
        do_reset();

        // Instruction memory never ready.
        prog.push_back(mk(OPC_OP, 1, 0, 0, 255, 0, 0));
        push_trap(16, 2'b10);
        run_prog(0);
        do_reset();

        // Illegal opcode after a good instruction.
        prog.push_back(mk(OPC_OP,  1, 0, 0, 0, 0, 0));
        prog.push_back(mk(7'h00,   1, 1, 1, 0, 0, 0));
        push_ret(4, 0, 1, 1, 0);
        push_trap(7, 2'b01);
        run_prog(0);
        do_reset();

        // Reset lands while a load is waiting in MEM.
        prog.push_back(mk(OPC_LOAD, 1, 0, 0, 0, 255, 0));
        run_prog(6);
        chk("mem_req_before_rst", {30'd0, mif.dmem_req, mif.dmem_we}, 32'd2);
        chk("mem_state_before_rst", {29'd0, state_o}, 32'd3);
        do_reset();

        // Clean store after the mid-MEM reset.
        prog.push_back(mk(OPC_STORE, 0, 1, 0, 0, 0, 0));
        push_ret(4, 0, 0, 1, 1);
        run_prog(0);
        do_reset();

`ifdef MCYC_PERF_CNT_EN
        for (int i = 1; i <= 10; i++) begin
            prog.push_back(mk(OPC_OP, 1, 0, 0, 0, 0, 0));
            push_ret(4 * i, 0, 1, 1, 0);
        end
        run_prog(40);
        chk("cycle_cnt", cycle_cnt, 32'd40);
        chk("instret_cnt", instret_cnt, 32'd10);
        do_reset();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
